// File: rtl/rx_tlp_fsm.sv
// rx_tlp_fsm
//   Control FSM for the PCIe receive path. Tracks TLP beats arriving on the
//   64-bit AXI-Stream RX interface and classifies each 3DW-header TLP as a
//   read, a write or malformed, using the keep/last pattern of header beat 2.
//   It drives the engine's register-load select so that rx_data is captured
//   on the same edge that a beat is accepted. It throttles rx_ready against
//   the OCP side and, for reads, pushes the captured header to the TX header
//   FIFO so that a completion can be built.
//
// Ports
//   rx_clk               : clock, all state changes on its rising edge
//   rx_reset             : asynchronous, active-low reset
//   rx_valid             : AXI RX beat valid
//   rx_keep              : AXI RX byte enables of the current beat
//   rx_last              : AXI RX last beat of the TLP
//   rx_ready             : AXI RX ready (forced low while in reset)
//   tx_header_fifo_ready : TX header FIFO can accept
//   tx_header_fifo_valid : header push request, high only while a completion waits
//   ocp_ready            : OCP side can accept a data-carrying beat
//   optype               : 00 none, 01 read, 10 write, 11 malformed (registered)
//   ocp_reg_ctl          : 000 IDLE, 001 H1, 010 H2, 011 DATA3, 100 DATA4 (Mealy)
module rx_tlp_fsm #(
  parameter int keep_width = 8
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset,
  input  logic                  rx_valid,
  input  logic [keep_width-1:0] rx_keep,
  input  logic                  rx_last,
  output logic                  rx_ready,
  input  logic                  tx_header_fifo_ready,
  output logic                  tx_header_fifo_valid,
  input  logic                  ocp_ready,
  output logic [1:0]            optype,
  output logic [2:0]            ocp_reg_ctl
);

  typedef enum logic [2:0] {
    S_HDR1    = 3'd0,
    S_HDR2    = 3'd1,
    S_DATA    = 3'd2,
    S_CPL     = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [2:0] CTL_IDLE  = 3'b000;
  localparam logic [2:0] CTL_H1    = 3'b001;
  localparam logic [2:0] CTL_H2    = 3'b010;
  localparam logic [2:0] CTL_DATA3 = 3'b011;
  localparam logic [2:0] CTL_DATA4 = 3'b100;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_BAD   = 2'b11;

  // A read header's second beat carries only the third header DW (low half
  // of the beat); a write's second beat also carries the first data DW.
  localparam logic [keep_width-1:0] KEEP_HALF =
    {{(keep_width/2){1'b0}}, {(keep_width/2){1'b1}}};
  localparam logic [keep_width-1:0] KEEP_FULL = {keep_width{1'b1}};

  state_t     r_state;
  logic [1:0] r_optype;

  logic w_stateReady;
  logic w_accept;
  logic w_keepHalf;
  logic w_keepFull;

  assign w_keepHalf = (rx_keep == KEEP_HALF);
  assign w_keepFull = (rx_keep == KEEP_FULL);

  // Ready as seen by the current state; beats that must reach the OCP side
  // are throttled by ocp_ready, and nothing is accepted while a completion
  // header waits for the TX FIFO.
  always_comb begin
    w_stateReady = 1'b0;
    case (r_state)
      S_HDR1:    w_stateReady = 1'b1;
      S_HDR2:    w_stateReady = ocp_ready;
      S_DATA:    w_stateReady = ocp_ready;
      S_CPL:     w_stateReady = 1'b0;
      S_DISCARD: w_stateReady = 1'b1;
      default:   w_stateReady = 1'b0;
    endcase
  end

  // Reset gates ready directly so nothing is handshaken during reset.
  assign rx_ready             = rx_reset & w_stateReady;
  assign w_accept             = rx_valid & rx_ready;
  assign tx_header_fifo_valid = (r_state == S_CPL);
  assign optype               = r_optype;

  // Register-load select is issued only on an accepted beat, so the engine
  // can capture rx_data on the very edge that completes the handshake.
  always_comb begin
    ocp_reg_ctl = CTL_IDLE;
    if (w_accept) begin
      case (r_state)
        S_HDR1: ocp_reg_ctl = rx_last ? CTL_IDLE : CTL_H1;
        S_HDR2: begin
          if ((w_keepHalf && rx_last) || w_keepFull) ocp_reg_ctl = CTL_H2;
          else                                       ocp_reg_ctl = CTL_IDLE;
        end
        S_DATA:  ocp_reg_ctl = rx_last ? CTL_DATA4 : CTL_DATA3;
        default: ocp_reg_ctl = CTL_IDLE;
      endcase
    end
  end

  // State and TLP classification. A malformed header beat 2 that is not
  // last sends the rest of the TLP to S_DISCARD so its data is not loaded.
  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      r_state  <= S_HDR1;
      r_optype <= OP_NONE;
    end else begin
      case (r_state)
        S_HDR1: begin
          if (w_accept) begin
            if (rx_last) begin
              r_optype <= OP_BAD;
            end else begin
              r_optype <= OP_NONE;
              r_state  <= S_HDR2;
            end
          end
        end
        S_HDR2: begin
          if (w_accept) begin
            if (w_keepHalf && rx_last) begin
              r_optype <= OP_READ;
              r_state  <= S_CPL;
            end else if (w_keepFull) begin
              r_optype <= OP_WRITE;
              r_state  <= rx_last ? S_HDR1 : S_DATA;
            end else begin
              r_optype <= OP_BAD;
              r_state  <= rx_last ? S_HDR1 : S_DISCARD;
            end
          end
        end
        S_DATA: begin
          if (w_accept && rx_last) r_state <= S_HDR1;
        end
        S_CPL: begin
          if (tx_header_fifo_ready) r_state <= S_HDR1;
        end
        S_DISCARD: begin
          if (w_accept && rx_last) r_state <= S_HDR1;
        end
        default: r_state <= S_HDR1;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_tlp_fsm.sv
// Testbench for rx_tlp_fsm: directed vector table, hand-written reset
// sequences, then randomized traffic checked against a beat-counting model.
module tb_rx_tlp_fsm;

  logic       rx_clk;
  logic       rx_reset;
  logic       rx_valid;
  logic [7:0] rx_keep;
  logic       rx_last;
  logic       rx_ready;
  logic       tx_header_fifo_ready;
  logic       tx_header_fifo_valid;
  logic       ocp_ready;
  logic [1:0] optype;
  logic [2:0] ocp_reg_ctl;

  int testsRun    = 0;
  int testsFailed = 0;

  rx_tlp_fsm #(.keep_width(8)) dut (
    .rx_clk               (rx_clk),
    .rx_reset             (rx_reset),
    .rx_valid             (rx_valid),
    .rx_keep              (rx_keep),
    .rx_last              (rx_last),
    .rx_ready             (rx_ready),
    .tx_header_fifo_ready (tx_header_fifo_ready),
    .tx_header_fifo_valid (tx_header_fifo_valid),
    .ocp_ready            (ocp_ready),
    .optype               (optype),
    .ocp_reg_ctl          (ocp_reg_ctl)
  );

  // Free-running 100 MHz clock.
  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic       v;
    logic [7:0] keep;
    logic       last;
    logic       ocp;
    logic       fifo;
    logic       eRdy;
    logic [2:0] eCtl;
    logic [1:0] eOpt;
    logic       eFv;
  } vec_t;

  vec_t vecs[$];

  // Reference model: counts beats of the current TLP and remembers its class.
  // mKind: 0 unknown/idle, 2 write, 3 discarding rest of malformed TLP.
  int         mBeat;
  int         mKind;
  bit         mCpl;
  logic [1:0] mOpt;

  function automatic vec_t mk(logic v, logic [7:0] keep, logic last, logic ocp,
                              logic fifo, logic eRdy, logic [2:0] eCtl,
                              logic [1:0] eOpt, logic eFv);
    vec_t r;
    r.v = v; r.keep = keep; r.last = last; r.ocp = ocp; r.fifo = fifo;
    r.eRdy = eRdy; r.eCtl = eCtl; r.eOpt = eOpt; r.eFv = eFv;
    return r;
  endfunction

  // One comparison; prints a FAIL line on mismatch.
  task automatic checkOne(string what, int act, int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", what, act, exp, $time);
    end
  endtask

  // Compare every output of the block against the given expectations.
  task automatic checkOutput(string tag, logic eRdy, logic [2:0] eCtl,
                             logic [1:0] eOpt, logic eFv);
    checkOne({tag, " rx_ready"}, int'(rx_ready), int'(eRdy));
    checkOne({tag, " ocp_reg_ctl"}, int'(ocp_reg_ctl), int'(eCtl));
    checkOne({tag, " optype"}, int'(optype), int'(eOpt));
    checkOne({tag, " tx_header_fifo_valid"}, int'(tx_header_fifo_valid), int'(eFv));
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check the
  // outputs mid-cycle on the falling edge, then advance past the next edge.
  task automatic applyStimulus(string tag, vec_t s);
    rx_valid             = s.v;
    rx_keep              = s.keep;
    rx_last              = s.last;
    ocp_ready            = s.ocp;
    tx_header_fifo_ready = s.fifo;
    @(negedge rx_clk);
    checkOutput(tag, s.eRdy, s.eCtl, s.eOpt, s.eFv);
    @(posedge rx_clk);
    #1;
  endtask

  // Predict this cycle's outputs from the model and the current inputs.
  function automatic vec_t predict(vec_t s);
    vec_t  r;
    logic  acc;
    r = s;
    r.eFv  = mCpl;
    r.eOpt = mOpt;
    if (mCpl)                        r.eRdy = 1'b0;
    else if (mBeat == 0 || mKind == 3) r.eRdy = 1'b1;
    else                             r.eRdy = s.ocp;
    acc = s.v && r.eRdy;
    r.eCtl = 3'd0;
    if (acc) begin
      if (mBeat == 0)      r.eCtl = s.last ? 3'd0 : 3'd1;
      else if (mKind == 3) r.eCtl = 3'd0;
      else if (mBeat == 1) r.eCtl = ((s.keep == 8'h0F && s.last) || s.keep == 8'hFF) ? 3'd2 : 3'd0;
      else                 r.eCtl = s.last ? 3'd4 : 3'd3;
    end
    return r;
  endfunction

  // Advance the model across the rising edge that just happened.
  task automatic modelEdge(vec_t p);
    if (mCpl) begin
      if (p.fifo) mCpl = 0;
    end else if (p.v && p.eRdy) begin
      if (mBeat == 0) begin
        if (p.last) mOpt = 2'b11;
        else begin mOpt = 2'b00; mBeat = 1; end
      end else if (mKind == 3) begin
        if (p.last) begin mBeat = 0; mKind = 0; end
      end else if (mBeat == 1) begin
        if (p.keep == 8'h0F && p.last) begin
          mOpt = 2'b01; mCpl = 1; mBeat = 0;
        end else if (p.keep == 8'hFF) begin
          mOpt = 2'b10;
          if (p.last) mBeat = 0; else begin mBeat = 2; mKind = 2; end
        end else begin
          mOpt = 2'b11;
          if (p.last) mBeat = 0; else mKind = 3;
        end
      end else begin
        if (p.last) begin mBeat = 0; mKind = 0; end
        else mBeat++;
      end
    end
  endtask

  initial begin
    vec_t s;
    vec_t p;

    // Reset held with a valid beat offered: nothing may be handshaken.
    rx_reset = 1'b0; rx_valid = 1'b1; rx_keep = 8'hFF; rx_last = 1'b0;
    ocp_ready = 1'b1; tx_header_fifo_ready = 1'b0;
    repeat (2) @(posedge rx_clk);
    @(negedge rx_clk);
    checkOutput("reset", 1'b0, 3'd0, 2'd0, 1'b0);
    @(posedge rx_clk); #1;
    rx_reset = 1'b1; rx_valid = 1'b0;
    @(negedge rx_clk);
    checkOutput("reset release", 1'b1, 3'd0, 2'd0, 1'b0);
    @(posedge rx_clk); #1;

    // Directed table: read with FIFO stall, 4-beat write with backpressure,
    // malformed single beat, malformed keep with discard, single-DW write.
    //                    v  keep  l  ocp fifo rdy ctl opt fv
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 3'd1, 2'd0, 0));
    vecs.push_back(mk(1, 8'h0F, 1, 1, 0, 1, 3'd2, 2'd0, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 0, 3'd0, 2'd1, 1));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 0, 3'd0, 2'd1, 1));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 0, 3'd0, 2'd1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 3'd0, 2'd1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 3'd0, 2'd1, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 3'd1, 2'd1, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 3'd2, 2'd0, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 3'd0, 2'd2, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 3'd0, 2'd2, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 3'd3, 2'd2, 0));
    vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 1, 3'd4, 2'd2, 0));
    vecs.push_back(mk(1, 8'hFF, 1, 0, 0, 1, 3'd0, 2'd2, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 3'd0, 2'd3, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 3'd1, 2'd3, 0));
    vecs.push_back(mk(1, 8'h03, 0, 1, 0, 1, 3'd0, 2'd0, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 1, 3'd0, 2'd3, 0));
    vecs.push_back(mk(1, 8'hFF, 1, 0, 0, 1, 3'd0, 2'd3, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 3'd1, 2'd3, 0));
    vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 1, 3'd2, 2'd0, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 3'd1, 2'd2, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    vecs.push_back(mk(1, 8'h0F, 0, 1, 0, 1, 3'd0, 2'd0, 0));
    vecs.push_back(mk(1, 8'hF0, 1, 0, 0, 1, 3'd0, 2'd3, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 3'd0, 2'd3, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the middle of a write: the next beat is a fresh header 1.
    applyStimulus("midreset hdr", mk(1, 8'hFF, 0, 1, 0, 1, 3'd1, 2'd3, 0));
    rx_reset = 1'b0; rx_valid = 1'b1;
    @(negedge rx_clk);
    checkOutput("midreset held", 1'b0, 3'd0, 2'd0, 1'b0);
    @(posedge rx_clk); #1;
    rx_reset = 1'b1;
    applyStimulus("midreset next", mk(1, 8'hFF, 0, 1, 0, 1, 3'd1, 2'd0, 0));
    applyStimulus("midreset h2", mk(1, 8'h0F, 1, 1, 1, 1, 3'd2, 2'd0, 0));
    applyStimulus("midreset cpl", mk(0, 8'h00, 0, 1, 1, 0, 3'd0, 2'd1, 1));

    // Randomized traffic from a clean reset, checked against the model.
    rx_reset = 1'b0;
    @(posedge rx_clk); #1;
    rx_reset = 1'b1;
    mBeat = 0; mKind = 0; mCpl = 0; mOpt = 2'b00;
    for (int n = 0; n < 600; n++) begin
      s.v    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       s.keep = 8'hFF;
        1:       s.keep = 8'h0F;
        2:       s.keep = 8'hFF;
        default: s.keep = 8'($urandom);
      endcase
      s.last = ($urandom_range(0, 2) == 0);
      s.ocp  = ($urandom_range(0, 3) != 0);
      s.fifo = ($urandom_range(0, 1) == 1);
      p = predict(s);
      applyStimulus($sformatf("rand%0d", n), p);
      modelEdge(p);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rx_tlp_fsm.md
Name: rx_tlp_fsm

Overview:
- Control FSM for the PCIe receive path.
- Tracks TLP beats arriving on the 64-bit AXI-Stream RX interface, classifies each TLP as read or write from the keep/last pattern (3DW headers only), and drives the engine's header/data register-load selects (ocp_reg_ctl).
- Throttles rx_ready against the OCP side, and pushes the captured header of a read TLP into the TX header FIFO so a completion can be built.

Parameters:
- keep_width, 8: width of rx_keep (one bit per byte of a 64-bit beat).

Ports:
- rx_clk, input, 1: the single clock; all state changes on its rising edge.
- rx_reset, input, 1: asynchronous, active-low reset.
- rx_valid, input, 1: AXI RX beat valid.
- rx_keep, input, keep_width: AXI RX byte enables of the current beat.
- rx_last, input, 1: AXI RX last beat of the TLP.
- rx_ready, output, 1: AXI RX ready.
- tx_header_fifo_ready, input, 1: TX header FIFO can accept.
- tx_header_fifo_valid, output, 1: header push request to the TX header FIFO.
- ocp_ready, input, 1: OCP side can accept a data-carrying beat.
- optype, output, 2: TLP class. 00 none, 01 read, 10 write, 11 malformed.
- ocp_reg_ctl, output, 3: register-load select. 000 IDLE, 001 H1, 010 H2, 011 DATA3, 100 DATA4.

Behaviour:
- Beat accept: a beat is accepted when rx_valid && rx_ready at a rising edge of rx_clk.
- ocp_reg_ctl timing:
  - Combinational (Mealy). It carries the non-IDLE code only in a cycle where a beat is accepted; otherwise it is 000.
  - This lets the engine capture rx_data on the same edge.
- States:
  - S_HDR1: wait for header beat 1. rx_ready=1.
    - Accept with rx_last=0 -> ocp_reg_ctl=H1; optype <= 00; go to S_HDR2.
    - Accept with rx_last=1 -> ocp_reg_ctl=IDLE; optype <= 11; stay.
  - S_HDR2: rx_ready=ocp_ready.
    - Accept with keep=0x0F and last=1 -> H2; optype <= 01; go to S_CPL.
    - Accept with keep=0xFF and last=1 -> H2; optype <= 10; go to S_HDR1 (single-DW write).
    - Accept with keep=0xFF and last=0 -> H2; optype <= 10; go to S_DATA.
    - Any other keep -> IDLE code; optype <= 11; go to S_HDR1 if last, else S_DISCARD.
  - S_DATA: rx_ready=ocp_ready.
    - Accept with last=0 -> DATA3; stay.
    - Accept with last=1 (any keep) -> DATA4; go to S_HDR1.
  - S_CPL: rx_ready=0; tx_header_fifo_valid=1.
    - When tx_header_fifo_ready=1 at the edge -> go to S_HDR1.
    - tx_header_fifo_valid is 0 in every other state.
  - S_DISCARD: rx_ready=1; ocp_reg_ctl=IDLE.
    - Accept with last=1 -> go to S_HDR1.
- optype: registered. Holds its last value until the next update listed above.
- Reset values (rx_reset=0, asynchronous):
  - state=S_HDR1, optype=00.
  - rx_ready=0, tx_header_fifo_valid=0, ocp_reg_ctl=000.
  - rx_ready is forced 0 while reset is asserted.
- Reset mid-TLP: returns to S_HDR1. The next accepted beat is treated as header beat 1 (no resynchronisation).
- rx_valid=0 in any state: no transition; ocp_reg_ctl=000.
- ocp_ready low in S_HDR2/S_DATA: rx_ready=0, so the beat is held and no ocp_reg_ctl code is issued.
- rx_keep is ignored in S_HDR1, S_DATA and S_DISCARD.
- No back-to-back restriction: a new TLP header may be accepted in the cycle after the last beat (except after a read, which waits in S_CPL).

Test Plan:
- Reset: hold rx_reset=0 with rx_valid=1 -> rx_ready=0, ocp_reg_ctl=000, optype=00, tx_header_fifo_valid=0. Release reset -> rx_ready=1.
- Read TLP: beat1 keep=FF last=0, then beat2 keep=0F last=1, ocp_ready=1 ->
  - ocp_reg_ctl 001 then 010; optype=01.
  - Next cycle: tx_header_fifo_valid=1, rx_ready=0.
  - Hold tx_header_fifo_ready=0 for 3 cycles -> valid stays 1. Then ready=1 -> back to idle, rx_ready=1.
- 4-beat write: keep=FF on all beats, last on beat 4 -> ocp_reg_ctl 001, 010, 011, 100; optype=10; no FIFO push.
- Backpressure: mid write, ocp_ready=0 for 2 cycles -> rx_ready=0 and ocp_reg_ctl=000 for those cycles; sequence resumes unchanged when ocp_ready=1.
- Malformed:
  - Single beat with last=1 -> optype=11, ocp_reg_ctl=000, stay idle.
  - Beat2 keep=03 last=0, then 2 more beats ending last=1 -> beats accepted with ocp_reg_ctl=000, then idle.
- Single-DW write: beat2 keep=FF last=1 -> ocp_reg_ctl=010, optype=10; a new header beat is accepted the next cycle with code 001.
